// File: rtl/ycocg2rgb_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ycocg2rgb_pipe
//
// Two-stage pipelined inverse colour-space converter for the decoder output
// path. Each beat carries NUM_PX pixels. Stage 1 performs the YCoCg-R lifting
// inverse (or passes RGB straight through); stage 2 clips every component to
// the beat's bit depth and registers the result as the output beat. A
// saturating counter accumulates the number of clipped components seen on
// output transfers.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_bpc              bit depth code: 0=8, 1=10, 2=12, 3=8
//   in_csc_en           1 = YCoCg-R inverse, 0 = RGB bypass
//   in_c0/c1/c2         signed samples, pixel k at [k*IN_W +: IN_W]
//   out_valid/out_ready output handshake, full backpressure
//   out_r/g/b           clipped components, pixel k at [k*MAX_BPC +: MAX_BPC]
//   clr_cnt             synchronous clear of clip_cnt (wins over an add)
//   clip_cnt            saturating count of clipped components
// ---------------------------------------------------------------------------
module ycocg2rgb_pipe #(
    parameter int NUM_PX  = 2,
    parameter int MAX_BPC = 12,
    parameter int IN_W    = MAX_BPC + 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_bpc,
    input  logic                      in_csc_en,
    input  logic [NUM_PX*IN_W-1:0]    in_c0,
    input  logic [NUM_PX*IN_W-1:0]    in_c1,
    input  logic [NUM_PX*IN_W-1:0]    in_c2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_PX*MAX_BPC-1:0] out_r,
    output logic [NUM_PX*MAX_BPC-1:0] out_g,
    output logic [NUM_PX*MAX_BPC-1:0] out_b,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          clip_cnt
);

    // One extra bit of headroom for the lifting steps.
    localparam int SW  = IN_W + 1;
    localparam int NC  = 3 * NUM_PX;
    localparam int NCW = $clog2(NC + 1);

    logic                  adv1;
    logic                  adv2;
    logic                  s1_valid;
    logic [1:0]            s1_bpc_reg;
    int                    eff_bpc;
    logic signed [SW-1:0]  max_val;
    logic [NC-1:0]         clip_flags;
    logic [NCW-1:0]        nclip_next;
    logic [NCW-1:0]        nclip_reg;
    logic [CNT_W-1:0]      clip_cnt_reg;
    logic [CNT_W:0]        cnt_sum;

    // Returns {clipped_flag, clipped_value}.
    function automatic logic [MAX_BPC:0] clip_comp(
        input logic signed [SW-1:0] v,
        input logic signed [SW-1:0] mx
    );
        if (v[SW-1])
            clip_comp = {1'b1, {MAX_BPC{1'b0}}};
        else if (v > mx)
            clip_comp = {1'b1, mx[MAX_BPC-1:0]};
        else
            clip_comp = {1'b0, v[MAX_BPC-1:0]};
    endfunction

    // A stage may take new data when it is empty or the stage after it is
    // moving; this chains backpressure all the way to in_ready.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_bpc_reg <= 2'd0;
        end else if (adv1) begin
            s1_valid   <= in_valid;
            s1_bpc_reg <= in_bpc;
        end
    end

    // Depth travels with the beat, so the clip limit is derived from the
    // stage-1 copy rather than the live input.
    always_comb begin
        case (s1_bpc_reg)
            2'd1:    eff_bpc = 10;
            2'd2:    eff_bpc = 12;
            default: eff_bpc = 8;
        endcase
        if (eff_bpc > MAX_BPC)
            eff_bpc = MAX_BPC;
        max_val = SW'((1 << eff_bpc) - 1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PX; gi++) begin : g_px
            logic signed [SW-1:0] c0_ext;
            logic signed [SW-1:0] c1_ext;
            logic signed [SW-1:0] c2_ext;
            logic signed [SW-1:0] tmp;
            logic signed [SW-1:0] csc_r;
            logic signed [SW-1:0] csc_g;
            logic signed [SW-1:0] csc_b;
            logic signed [SW-1:0] r_reg;
            logic signed [SW-1:0] g_reg;
            logic signed [SW-1:0] b_reg;
            logic [MAX_BPC:0]     r_clip;
            logic [MAX_BPC:0]     g_clip;
            logic [MAX_BPC:0]     b_clip;
            logic [MAX_BPC-1:0]   r_out_reg;
            logic [MAX_BPC-1:0]   g_out_reg;
            logic [MAX_BPC-1:0]   b_out_reg;

            assign c0_ext = {in_c0[gi*IN_W + IN_W - 1], in_c0[gi*IN_W +: IN_W]};
            assign c1_ext = {in_c1[gi*IN_W + IN_W - 1], in_c1[gi*IN_W +: IN_W]};
            assign c2_ext = {in_c2[gi*IN_W + IN_W - 1], in_c2[gi*IN_W +: IN_W]};

            // YCoCg-R lifting inverse: c0=Y, c1=Co, c2=Cg.
            assign tmp   = c0_ext - (c2_ext >>> 1);
            assign csc_g = c2_ext + tmp;
            assign csc_b = tmp - (c1_ext >>> 1);
            assign csc_r = csc_b + c1_ext;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_reg <= '0;
                    g_reg <= '0;
                    b_reg <= '0;
                end else if (adv1) begin
                    r_reg <= in_csc_en ? csc_r : c0_ext;
                    g_reg <= in_csc_en ? csc_g : c1_ext;
                    b_reg <= in_csc_en ? csc_b : c2_ext;
                end
            end

            assign r_clip = clip_comp(r_reg, max_val);
            assign g_clip = clip_comp(g_reg, max_val);
            assign b_clip = clip_comp(b_reg, max_val);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out_reg <= '0;
                    g_out_reg <= '0;
                    b_out_reg <= '0;
                end else if (adv2) begin
                    r_out_reg <= r_clip[MAX_BPC-1:0];
                    g_out_reg <= g_clip[MAX_BPC-1:0];
                    b_out_reg <= b_clip[MAX_BPC-1:0];
                end
            end

            assign clip_flags[gi*3 +: 3] = {b_clip[MAX_BPC], g_clip[MAX_BPC], r_clip[MAX_BPC]};

            assign out_r[gi*MAX_BPC +: MAX_BPC] = r_out_reg;
            assign out_g[gi*MAX_BPC +: MAX_BPC] = g_out_reg;
            assign out_b[gi*MAX_BPC +: MAX_BPC] = b_out_reg;
        end
    endgenerate

    always_comb begin
        nclip_next = '0;
        for (int i = 0; i < NC; i++)
            nclip_next = nclip_next + NCW'(clip_flags[i]);
    end

    // The beat's clip count rides in stage 2 and is only added to the
    // counter when the beat actually leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            nclip_reg <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            nclip_reg <= nclip_next;
        end
    end

    assign cnt_sum = {1'b0, clip_cnt_reg} + (CNT_W+1)'(nclip_reg);

    always_ff @(posedge clk) begin
        if (!rst_n)
            clip_cnt_reg <= '0;
        else if (clr_cnt)
            clip_cnt_reg <= '0;
        else if (out_valid && out_ready)
            clip_cnt_reg <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    assign clip_cnt = clip_cnt_reg;

endmodule

// File: tb/tb_ycocg2rgb_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for ycocg2rgb_pipe: expected beats are computed from the
// inputs when a beat is accepted and compared when the beat leaves the DUT.
module tb_ycocg2rgb_pipe;

    localparam int NUM_PX  = 2;
    localparam int MAX_BPC = 12;
    localparam int IN_W    = MAX_BPC + 2;
    localparam int CNT_W   = 16;
    localparam int DW      = NUM_PX * IN_W;
    localparam int OW      = NUM_PX * MAX_BPC;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_bpc;
    logic             in_csc_en;
    logic [DW-1:0]    in_c0;
    logic [DW-1:0]    in_c1;
    logic [DW-1:0]    in_c2;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_r;
    logic [OW-1:0]    out_g;
    logic [OW-1:0]    out_b;
    logic             clr_cnt;
    logic [CNT_W-1:0] clip_cnt;

    typedef struct {
        logic [OW-1:0] r;
        logic [OW-1:0] g;
        logic [OW-1:0] b;
        int            nclip;
        int            acc_cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            cyc       = 0;
    int            cnt_model = 0;
    bit            check_lat = 0;
    logic [OW-1:0] last_r;
    logic [OW-1:0] last_g;
    logic [OW-1:0] last_b;

    ycocg2rgb_pipe #(
        .NUM_PX (NUM_PX),
        .MAX_BPC(MAX_BPC),
        .IN_W   (IN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bpc   (in_bpc),
        .in_csc_en(in_csc_en),
        .in_c0    (in_c0),
        .in_c1    (in_c1),
        .in_c2    (in_c2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_g    (out_g),
        .out_b    (out_b),
        .clr_cnt  (clr_cnt),
        .clip_cnt (clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clip_val(input int v, input int mx, inout int n);
        if (v < 0) begin
            n++;
            return 0;
        end
        if (v > mx) begin
            n++;
            return mx;
        end
        return v;
    endfunction

    function automatic exp_t model(input logic [1:0] bpc, input logic csc,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] c);
        exp_t e;
        int eff, mx, n, y, co, cg, tmp, rr, gg, bb;
        logic signed [IN_W-1:0] sa, sb, sc;
        eff = (bpc == 2'd1) ? 10 : (bpc == 2'd2) ? 12 : 8;
        mx  = (1 << eff) - 1;
        n   = 0;
        e.r = '0;
        e.g = '0;
        e.b = '0;
        for (int k = 0; k < NUM_PX; k++) begin
            sa = a[k*IN_W +: IN_W];
            sb = b[k*IN_W +: IN_W];
            sc = c[k*IN_W +: IN_W];
            y  = sa;
            co = sb;
            cg = sc;
            if (csc) begin
                tmp = y - (cg >>> 1);
                gg  = cg + tmp;
                bb  = tmp - (co >>> 1);
                rr  = bb + co;
            end else begin
                rr = y;
                gg = co;
                bb = cg;
            end
            e.r[k*MAX_BPC +: MAX_BPC] = MAX_BPC'(clip_val(rr, mx, n));
            e.g[k*MAX_BPC +: MAX_BPC] = MAX_BPC'(clip_val(gg, mx, n));
            e.b[k*MAX_BPC +: MAX_BPC] = MAX_BPC'(clip_val(bb, mx, n));
        end
        e.nclip   = n;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: samples on the falling edge, i.e. the state the next rising
    // edge will act on.
    initial begin
        logic          stalled;
        logic [OW-1:0] pr, pg, pb;
        exp_t          e;
        int            nxt;
        stalled = 1'b0;
        pr = '0;
        pg = '0;
        pb = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sb_q.delete();
                cnt_model = 0;
                stalled   = 1'b0;
            end else begin
                check_eq("clip_cnt", clip_cnt, cnt_model);
                if (stalled) begin
                    check_eq("hold_r", out_r, pr);
                    check_eq("hold_g", out_g, pg);
                    check_eq("hold_b", out_b, pb);
                end
                nxt = cnt_model;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_beat", out_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("out_r", out_r, e.r);
                        check_eq("out_g", out_g, e.g);
                        check_eq("out_b", out_b, e.b);
                        if (check_lat)
                            check_eq("latency", cyc - e.acc_cyc, 2);
                        last_r = out_r;
                        last_g = out_g;
                        last_b = out_b;
                        nxt = cnt_model + e.nclip;
                        if (nxt > CNT_MAX)
                            nxt = CNT_MAX;
                    end
                end
                if (clr_cnt)
                    nxt = 0;
                cnt_model = nxt;
                stalled = out_valid && !out_ready;
                pr = out_r;
                pg = out_g;
                pb = out_b;
                if (in_valid && in_ready) begin
                    e = model(in_bpc, in_csc_en, in_c0, in_c1, in_c2);
                    e.acc_cyc = cyc;
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

    task automatic send();
        int t;
        t = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200)
            check_eq("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic beat(input logic [1:0] bpc, input logic csc, input int y, input int co, input int cg);
        in_bpc    = bpc;
        in_csc_en = csc;
        for (int k = 0; k < NUM_PX; k++) begin
            in_c0[k*IN_W +: IN_W] = IN_W'(y);
            in_c1[k*IN_W +: IN_W] = IN_W'(co);
            in_c2[k*IN_W +: IN_W] = IN_W'(cg);
        end
        send();
    endtask

    task automatic rand_beat();
        in_bpc    = 2'($urandom_range(0, 3));
        in_csc_en = 1'($urandom_range(0, 1));
        for (int k = 0; k < NUM_PX; k++) begin
            in_c0[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 5000)) - 2500);
            in_c1[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 3000)) - 1500);
            in_c2[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 3000)) - 1500);
        end
        send();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0)
            check_eq("drain_timeout", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, t1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bpc    = 2'd0;
        in_csc_en = 1'b0;
        in_c0     = '0;
        in_c1     = '0;
        in_c2     = '0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_r", out_r, 0);
        check_eq("rst_out_g", out_g, 0);
        check_eq("rst_out_b", out_b, 0);
        check_eq("rst_clip_cnt", clip_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors, both pixels carry the same sample.
        check_lat = 1;
        beat(2'd0, 1'b1, 100, 20, 10);
        drain();
        check_eq("t1_r", last_r[11:0], 105);
        check_eq("t1_g", last_g[11:0], 105);
        check_eq("t1_b", last_b[11:0], 85);
        check_eq("t1_cnt", clip_cnt, 0);

        beat(2'd0, 1'b1, 300, 0, 0);
        drain();
        check_eq("t2a_r", last_r[23:12], 255);
        check_eq("t2a_cnt", clip_cnt, 6);

        beat(2'd0, 1'b1, 0, -50, 0);
        drain();
        check_eq("t2b_r", last_r[11:0], 0);
        check_eq("t2b_b", last_b[11:0], 25);
        check_eq("t2b_cnt", clip_cnt, 8);

        beat(2'd2, 1'b1, 4000, 0, 200);
        drain();
        check_eq("t3_12_g", last_g[11:0], 4095);
        check_eq("t3_12_b", last_b[11:0], 3900);
        check_eq("t3_12_r", last_r[11:0], 3900);
        check_eq("t3_12_cnt", clip_cnt, 10);

        beat(2'd1, 1'b1, 4000, 0, 200);
        drain();
        check_eq("t3_10_r", last_r[11:0], 1023);
        check_eq("t3_10_b", last_b[11:0], 1023);
        check_eq("t3_10_cnt", clip_cnt, 16);

        beat(2'd1, 1'b0, -5, 512, 2000);
        drain();
        check_eq("t4_r", last_r[11:0], 0);
        check_eq("t4_g", last_g[11:0], 512);
        check_eq("t4_b", last_b[11:0], 1023);
        check_eq("t4_cnt", clip_cnt, 20);

        beat(2'd3, 1'b1, 300, 0, 0);
        drain();
        check_eq("t5_rsvd_g", last_g[11:0], 255);
        check_eq("t5_cnt", clip_cnt, 26);

        // Back-to-back stream with continuous out_ready: one accept per cycle.
        t0 = 0;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            if (i == 0)
                t0 = cyc;
        end
        t1 = cyc;
        check_eq("throughput", t1 - t0, 7);
        drain();

        // Backpressure: fill the pipe, hold, then random out_ready.
        check_lat = 0;
        out_ready = 1'b0;
        rand_beat();
        rand_beat();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("full_in_ready", in_ready, 0);
            check_eq("full_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    rand_beat();
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation: 6 clips per beat, more than enough beats to hit the top.
        check_lat = 1;
        for (int i = 0; i < 11000; i++)
            beat(2'd0, 1'b1, 4000, 0, 0);
        drain();
        check_eq("sat_cnt", clip_cnt, CNT_MAX);
        beat(2'd0, 1'b1, 4000, 0, 0);
        drain();
        check_eq("sat_hold", clip_cnt, CNT_MAX);

        // Clear coincident with a clipped transfer.
        beat(2'd0, 1'b1, 4000, 0, 0);
        @(posedge clk);
        #1;
        check_eq("clr_out_valid", out_valid, 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check_eq("clr_drained", sb_q.size(), 0);
        check_eq("clr_cnt", clip_cnt, 0);

        // Reset with two beats in flight.
        check_lat = 0;
        out_ready = 1'b0;
        beat(2'd0, 1'b1, 300, 0, 0);
        beat(2'd0, 1'b1, 300, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_clip_cnt", clip_cnt, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("postrst_out_valid", out_valid, 0);
        check_eq("postrst_in_ready", in_ready, 1);
        check_eq("postrst_q", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ycocg2rgb_pipe.md
Name: ycocg2rgb_pipe

Overview:
Pipelined, parametrised inverse colour-space converter for the decoder output path. Converts NUM_PX pixels per beat from YCoCg-R (or passes RGB through) to clipped RGB. Bit depth is selectable per beat via a 2-bit code, with 8, 10 and 12 bpc all distinctly supported. Uses a valid/ready handshake with full backpressure, and keeps a saturating count of clipped samples for debug/status.

Parameters:
NUM_PX, 2, pixels per beat
MAX_BPC, 12, maximum bits per component at output
IN_W, MAX_BPC+2, signed input sample width
CNT_W, 16, clip counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_bpc  in  2  0=8, 1=10, 2=12, 3=reserved (treated as 8)
in_csc_en  in  1  1=YCoCg-R inverse, 0=RGB bypass
in_c0  in  NUM_PX*IN_W  Y (csc) or R (bypass), signed, pixel k at [k*IN_W +: IN_W]
in_c1  in  NUM_PX*IN_W  Co or G, signed
in_c2  in  NUM_PX*IN_W  Cg or B, signed
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_r  out  NUM_PX*MAX_BPC  clipped R, pixel k at [k*MAX_BPC +: MAX_BPC]
out_g  out  NUM_PX*MAX_BPC  clipped G
out_b  out  NUM_PX*MAX_BPC  clipped B
clr_cnt  in  1  synchronous clear of clip_cnt
clip_cnt  out  CNT_W  saturating count of clipped components

Behaviour:
- Clock/reset: one clock clk; reset rst_n is synchronous, active-low.
- Reset: s1_valid, s2_valid, out_valid=0; out_r/g/b=0; clip_cnt=0. in_ready=1 in the cycle after reset deasserts.
- Pipeline: 2 registered stages; latency 2 cycles from accept to out_valid with no stall.
- Stage 1 (per pixel, signed IN_W+1 arithmetic, >>> is arithmetic shift):
  - csc_en=1: temp=Y-(Cg>>>1); G=Cg+temp; B=temp-(Co>>>1); R=B+Co.
  - csc_en=0: R=c0, G=c1, B=c2.
  - bpc code registered alongside the data.
- Stage 2 clip per component, with maxVal=(1<<bpc)-1:
  - value<0 -> 0.
  - value>maxVal -> maxVal.
  - otherwise the value itself, zero-extended to MAX_BPC.
  - A clipped flag is set for each component changed by either rule.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational).
  - A stage loads only when it advances.
  - Data is held stable while out_valid && !out_ready.
  - No beat is dropped or duplicated; a full pipe plus stall asserts in_ready=0.
- Simultaneous accept-in and emit-out in the same cycle sustains 1 beat/cycle throughput.
- Config is per beat: a bpc/csc change between beats applies only to the new beat, with no flush needed.
- clip_cnt:
  - On each output transfer (out_valid && out_ready), add the number of clipped flags in the beat (0..3*NUM_PX).
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt has priority over an add in the same cycle (result 0).
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- MAX_BPC<12: code 2 is treated as MAX_BPC; widths are otherwise generic.

Test Plan:
- bpc=8, csc=1, Y=100, Co=20, Cg=10 -> R=105, G=105, B=85, no clip; out_valid exactly 2 cycles after accept, clip_cnt unchanged.
- bpc=8, csc=1, Y=300, Co=0, Cg=0 -> R=G=B=255, clip_cnt+=3; Y=0, Co=-50, Cg=0 -> R=0, G=0, B=25, clip_cnt+=1.
- bpc=12, Y=4000, Co=0, Cg=200 -> G=4095 (clipped), B=3900, R=3900; bpc=10 with the same input -> R=G=B=1023, confirming 10- and 12-bit are distinct.
- csc=0 bypass, bpc=10, c0=-5, c1=512, c2=2000 -> R=0, G=512, B=1023, clip_cnt+=2.
- Backpressure: stream 8 beats with out_ready toggling randomly (hold low 3 cycles) -> in_ready drops when the pipe is full, output order and values match the model, and continuous out_ready gives 1 beat/cycle.
- Counter: preload near saturation via repeated clipped beats -> holds at 65535; clr_cnt asserted coincident with a clipped transfer -> clip_cnt=0. Reset asserted with 2 beats in flight -> out_valid=0 the next cycle and no stale beat after release.
